issue_select_queue: RTL and testbench

Issue-queue stage fed by the Dispatch→Select interface. It buffers dispatched micro-ops in a small reservation station and tracks source-operand readiness from wakeup tag broadcasts. Each cycle it selects one ready entry and hands that entry's payload-RAM index and destination tag to the issue/payload-read stage. It supplies dispatch backpressure and supports a full flush.

---
 rtl/issue_select_queue_pkg.sv | 28 ++
 rtl/issue_select_queue_age_matrix.sv | 44 ++++
 rtl/issue_select_queue.sv | 136 +++++++++++++
 tb/tb_issue_select_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_queue_pkg.sv
// Shared types and constants for the issue-select queue.
// The optional ISSUE_AGE_ORDER_EN build only changes the select policy, not these types.
package issue_select_queue_pkg;

    localparam int ISSUE_ENTRIES = 8;
    localparam int CORE_TAG_W    = 6;
    localparam int NUM_FUS       = 4;
    localparam int FU_IDX_W      = $clog2(NUM_FUS);

    typedef struct packed {
        logic [CORE_TAG_W-1:0] src1_tag;
        logic                  src1_ready;
        logic [CORE_TAG_W-1:0] src2_tag;
        logic                  src2_ready;
        logic [CORE_TAG_W-1:0] dst_tag;
    } DispUOP;

    typedef struct packed {
        logic                  valid;
        logic                  s1_rdy;
        logic                  s2_rdy;
        logic [CORE_TAG_W-1:0] s1_tag;
        logic [CORE_TAG_W-1:0] s2_tag;
        logic [CORE_TAG_W-1:0] dst_tag;
        logic [FU_IDX_W-1:0]   payload_idx;
    } IQEntry;

endpackage

// File: rtl/issue_select_queue_age_matrix.sv
// Age matrix for oldest-first select; only built when ISSUE_AGE_ORDER_EN is defined.
// older[i][j] = 1 means entry j was allocated before entry i and is still valid.
`ifdef ISSUE_AGE_ORDER_EN
module iq_age_matrix #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [N-1:0] alloc_oh,
    input  logic [N-1:0] free_oh,
    input  logic [N-1:0] valid_vec,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant_oh
);

    logic [N-1:0] older [N];

    // Freed columns are cleared so a reused slot never looks older than its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (free_oh[j])
                        older[i][j] <= 1'b0;
                    else if (alloc_oh[i])
                        older[i][j] <= valid_vec[j];
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < N; i++)
            grant_oh[i] = req[i] && ((older[i] & req) == '0);
    end

endmodule
`endif

// File: rtl/issue_select_queue.sv
// Reservation-station issue queue: allocate, wakeup, select one ready entry per cycle.
// Define ISSUE_AGE_ORDER_EN for oldest-first select; otherwise lowest index wins.
module issue_select_queue
    import issue_select_queue_pkg::*;
#(
    parameter int NUM_ENTRIES = ISSUE_ENTRIES,
    parameter int NUM_WAKEUP  = 2,
    parameter int TAG_W       = CORE_TAG_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                disp_valid,
    input  DispUOP                              disp_uop,
    input  logic [FU_IDX_W-1:0]                 payload_ram_index,
    output logic                                disp_ready,
    input  logic [NUM_WAKEUP-1:0]               wakeup_valid,
    input  logic [NUM_WAKEUP-1:0][TAG_W-1:0]    wakeup_tag,
    output logic                                issue_valid,
    input  logic                                issue_ready,
    output logic [FU_IDX_W-1:0]                 issue_payload_idx,
    output logic [TAG_W-1:0]                    issue_dst_tag,
    input  logic                                flush,
    output logic [$clog2(NUM_ENTRIES):0]        occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    IQEntry                  entries [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  valid_vec, req, grant_oh, free_oh, alloc_oh;
    logic [NUM_ENTRIES-1:0]  s1_hit, s2_hit;
    logic                    d1_hit, d2_hit, alloc, fire, any_req;
    logic [IDX_W-1:0]        alloc_idx, grant_idx;

    function automatic logic wake_hit(input logic [TAG_W-1:0] tag,
                                      input logic [NUM_WAKEUP-1:0] wv,
                                      input logic [NUM_WAKEUP-1:0][TAG_W-1:0] wt);
        wake_hit = 1'b0;
        for (int p = 0; p < NUM_WAKEUP; p++)
            if (wv[p] && wt[p] == tag) wake_hit = 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] first_free(input logic [NUM_ENTRIES-1:0] v);
        first_free = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!v[i]) first_free = IDX_W'(i);
    endfunction

    function automatic logic [NUM_ENTRIES-1:0] lowest_one(input logic [NUM_ENTRIES-1:0] r);
        lowest_one = r & (~r + NUM_ENTRIES'(1));
    endfunction

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_ENTRIES-1:0] oh);
        oh_to_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (oh[i]) oh_to_idx = oh_to_idx | IDX_W'(i);
    endfunction

    function automatic logic [IDX_W:0] count_ones(input logic [NUM_ENTRIES-1:0] v);
        count_ones = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            count_ones = count_ones + (IDX_W+1)'(v[i]);
    endfunction

    always_comb begin
        valid_vec = '0;
        req       = '0;
        s1_hit    = '0;
        s2_hit    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
            req[i]       = entries[i].valid && entries[i].s1_rdy && entries[i].s2_rdy;
            s1_hit[i]    = wake_hit(entries[i].s1_tag, wakeup_valid, wakeup_tag);
            s2_hit[i]    = wake_hit(entries[i].s2_tag, wakeup_valid, wakeup_tag);
        end
    end

    assign d1_hit     = wake_hit(disp_uop.src1_tag, wakeup_valid, wakeup_tag);
    assign d2_hit     = wake_hit(disp_uop.src2_tag, wakeup_valid, wakeup_tag);
    assign disp_ready = ~&valid_vec;
    assign occupancy  = count_ones(valid_vec);
    assign alloc      = disp_valid && disp_ready && !flush;
    assign alloc_idx  = first_free(valid_vec);

    always_comb begin
        alloc_oh = '0;
        if (alloc) alloc_oh[alloc_idx] = 1'b1;
    end

`ifdef ISSUE_AGE_ORDER_EN
    iq_age_matrix #(.N(NUM_ENTRIES)) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alloc_oh  (alloc_oh),
        .free_oh   (free_oh),
        .valid_vec (valid_vec),
        .req       (req),
        .grant_oh  (grant_oh)
    );
`else
    assign grant_oh = lowest_one(req);
`endif

    assign any_req           = |req;
    assign grant_idx         = oh_to_idx(grant_oh);
    assign issue_valid       = any_req && !flush;
    assign issue_payload_idx = any_req ? entries[grant_idx].payload_idx : '0;
    assign issue_dst_tag     = any_req ? entries[grant_idx].dst_tag : '0;
    assign fire              = issue_valid && issue_ready;
    assign free_oh           = fire ? grant_oh : '0;

    // Allocation only targets a free slot, so it never collides with issue or wakeup of that slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (free_oh[i]) entries[i].valid <= 1'b0;
                if (entries[i].valid && s1_hit[i]) entries[i].s1_rdy <= 1'b1;
                if (entries[i].valid && s2_hit[i]) entries[i].s2_rdy <= 1'b1;
                if (alloc_oh[i]) begin
                    entries[i].valid       <= 1'b1;
                    entries[i].s1_rdy      <= disp_uop.src1_ready || d1_hit;
                    entries[i].s2_rdy      <= disp_uop.src2_ready || d2_hit;
                    entries[i].s1_tag      <= disp_uop.src1_tag;
                    entries[i].s2_tag      <= disp_uop.src2_tag;
                    entries[i].dst_tag     <= disp_uop.dst_tag;
                    entries[i].payload_idx <= payload_ram_index;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_select_queue.sv
// Directed-vector bench for issue_select_queue with hand-computed expectations.
// Age-order expectations follow ISSUE_AGE_ORDER_EN when the bench is built with it.
module tb_issue_select_queue;
    import issue_select_queue_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            disp_valid;
    DispUOP          disp_uop;
    logic [1:0]      payload_ram_index;
    logic            disp_ready;
    logic [1:0]      wakeup_valid;
    logic [1:0][5:0] wakeup_tag;
    logic            issue_valid;
    logic            issue_ready;
    logic [1:0]      issue_payload_idx;
    logic [5:0]      issue_dst_tag;
    logic            flush;
    logic [3:0]      occupancy;

    int num_compared   = 0;
    int num_mismatched = 0;
    int age_first, age_second;

    issue_select_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .disp_valid        (disp_valid),
        .disp_uop          (disp_uop),
        .payload_ram_index (payload_ram_index),
        .disp_ready        (disp_ready),
        .wakeup_valid      (wakeup_valid),
        .wakeup_tag        (wakeup_tag),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_payload_idx (issue_payload_idx),
        .issue_dst_tag     (issue_dst_tag),
        .flush             (flush),
        .occupancy         (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [5:0] s1t, input logic s1r,
                                 input logic [5:0] s2t, input logic s2r,
                                 input logic [5:0] dst, input logic [1:0] pidx,
                                 input logic [1:0] wv, input logic [5:0] wt0,
                                 input logic [5:0] wt1, input logic ir, input logic fl);
        disp_valid          = dv;
        disp_uop.src1_tag   = s1t;
        disp_uop.src1_ready = s1r;
        disp_uop.src2_tag   = s2t;
        disp_uop.src2_ready = s2r;
        disp_uop.dst_tag    = dst;
        payload_ram_index   = pidx;
        wakeup_valid        = wv;
        wakeup_tag[0]       = wt0;
        wakeup_tag[1]       = wt1;
        issue_ready         = ir;
        flush               = fl;
    endtask

    task automatic idle(input logic ir);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, ir, 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(0);
        @(negedge clk);
        checkOutput("rst_disp_ready", 32'(disp_ready), 1);
        checkOutput("rst_occupancy", 32'(occupancy), 0);
        checkOutput("rst_issue_valid", 32'(issue_valid), 0);
        checkOutput("rst_payload_idx", 32'(issue_payload_idx), 0);
        checkOutput("rst_dst_tag", 32'(issue_dst_tag), 0);
        #2 rst_n = 1'b1;
        tick();

        // Ready uop goes straight through.
        applyStimulus(1, 0, 1, 0, 1, 9, 2, 2'b00, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("t1_empty_valid", 32'(issue_valid), 0);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t1_issue_valid", 32'(issue_valid), 1);
        checkOutput("t1_payload_idx", 32'(issue_payload_idx), 2);
        checkOutput("t1_dst_tag", 32'(issue_dst_tag), 9);
        checkOutput("t1_occ_busy", 32'(occupancy), 1);
        tick();
        @(negedge clk);
        checkOutput("t1_occ_after", 32'(occupancy), 0);
        checkOutput("t1_valid_after", 32'(issue_valid), 0);
        tick();

        // Late wakeup of src1 tag 5.
        applyStimulus(1, 5, 0, 0, 1, 10, 1, 2'b00, 0, 0, 1, 0);
        @(negedge clk);
        tick();
        for (int c = 0; c < 2; c++) begin
            idle(1);
            @(negedge clk);
            checkOutput("t2_wait", 32'(issue_valid), 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1, 0);
        @(negedge clk);
        checkOutput("t2_wake_cycle", 32'(issue_valid), 0);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t2_issue_valid", 32'(issue_valid), 1);
        checkOutput("t2_dst_tag", 32'(issue_dst_tag), 10);
        checkOutput("t2_payload_idx", 32'(issue_payload_idx), 1);
        tick();
        @(negedge clk);
        checkOutput("t2_occ_after", 32'(occupancy), 0);
        tick();

        // Same-cycle wakeup bypass on src2 via port 1.
        applyStimulus(1, 0, 1, 7, 0, 11, 3, 2'b10, 0, 7, 1, 0);
        @(negedge clk);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t3_bypass_valid", 32'(issue_valid), 1);
        checkOutput("t3_dst_tag", 32'(issue_dst_tag), 11);
        checkOutput("t3_payload_idx", 32'(issue_payload_idx), 3);
        tick();
        @(negedge clk);
        checkOutput("t3_occ_after", 32'(occupancy), 0);
        tick();

        // Fill all eight entries, none ready.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 20, 0, 0, 1, 6'(i + 1), 2'(i % 4), 2'b00, 0, 0, 0, 0);
            @(negedge clk);
            if (i == 7) begin
                checkOutput("t4_ready_at7", 32'(disp_ready), 1);
                checkOutput("t4_occ_at7", 32'(occupancy), 7);
            end
            tick();
        end
        idle(0);
        @(negedge clk);
        checkOutput("t4_full_occ", 32'(occupancy), 8);
        checkOutput("t4_full_ready", 32'(disp_ready), 0);
        checkOutput("t4_full_valid", 32'(issue_valid), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 20, 0, 0, 0);
        @(negedge clk);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t4_sel_valid", 32'(issue_valid), 1);
        checkOutput("t4_sel_dst", 32'(issue_dst_tag), 1);
        checkOutput("t4_ready_during", 32'(disp_ready), 0);
        tick();
        idle(0);
        @(negedge clk);
        checkOutput("t4_ready_after", 32'(disp_ready), 1);
        checkOutput("t4_occ_after", 32'(occupancy), 7);
        checkOutput("t4_next_dst", 32'(issue_dst_tag), 2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t4_flush_mask", 32'(issue_valid), 0);
        tick();
        idle(0);
        @(negedge clk);
        checkOutput("t4_flush_occ", 32'(occupancy), 0);
        tick();

        // Age order: A (older) lands in entry 1, B (younger) in entry 0.
`ifdef ISSUE_AGE_ORDER_EN
        age_first  = 41;
        age_second = 42;
`else
        age_first  = 42;
        age_second = 41;
`endif
        applyStimulus(1, 0, 1, 0, 1, 40, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        applyStimulus(1, 12, 0, 0, 1, 41, 1, 2'b00, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("t5_p_dst", 32'(issue_dst_tag), 40);
        tick();
        applyStimulus(1, 13, 0, 0, 1, 42, 2, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_occ_a", 32'(occupancy), 1);
        checkOutput("t5_none_ready", 32'(issue_valid), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 13, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_occ_ab", 32'(occupancy), 2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 12, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_b_only_dst", 32'(issue_dst_tag), 42);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t5_first_dst", 32'(issue_dst_tag), age_first);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t5_second_dst", 32'(issue_dst_tag), age_second);
        tick();
        idle(0);
        @(negedge clk);
        checkOutput("t5_occ_after", 32'(occupancy), 0);
        tick();

        // Flush with a same-cycle dispatch on a three-entry queue.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 0, 1, 6'(50 + i), 2'(i), 2'b00, 0, 0, 0, 0);
            @(negedge clk);
            tick();
        end
        idle(0);
        @(negedge clk);
        checkOutput("t6_occ3", 32'(occupancy), 3);
        checkOutput("t6_head_dst", 32'(issue_dst_tag), 50);
        tick();
        applyStimulus(1, 0, 1, 0, 1, 60, 1, 2'b00, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t6_flush_valid", 32'(issue_valid), 0);
        tick();
        idle(0);
        @(negedge clk);
        checkOutput("t6_occ_after", 32'(occupancy), 0);
        checkOutput("t6_valid_after", 32'(issue_valid), 0);
        checkOutput("t6_dst_zero", 32'(issue_dst_tag), 0);
        checkOutput("t6_ready_after", 32'(disp_ready), 1);
        tick();
        applyStimulus(1, 0, 1, 0, 1, 61, 3, 2'b00, 0, 0, 1, 0);
        @(negedge clk);
        tick();
        idle(1);
        @(negedge clk);
        checkOutput("t6_post_dst", 32'(issue_dst_tag), 61);
        checkOutput("t6_post_idx", 32'(issue_payload_idx), 3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
